// File: rtl/seq_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_gen_pkg
//  Brief    : Shared defaults, FSM state encoding and sizing helper for the
//             serial pattern generator.
//  Revision : 1.0  initial release
// ============================================================================
package seq_gen_pkg;

  localparam int         DEF_PAT_W       = 4;
  localparam int         DEF_CNT_W       = 4;
  localparam logic [3:0] DEF_PAT_DEFAULT = 4'b1010;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SHIFT  = 2'd1;
  localparam logic [1:0] c_PARITY = 2'd2;

  // Width of a counter that indexes bit positions PAT_W-1 down to 0.
  function automatic int idx_w(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_gen_if
//  Brief    : Request/stream bundle between a pattern-generator client
//             (master) and the generator itself (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface seq_pattern_gen_if
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic             use_default;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] rpt;
  logic             hold;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, use_default, pattern, rpt, hold,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, use_default, pattern, rpt, hold,
    output out, out_valid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/seq_pattern_gen_frame_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : seq_frame_shifter
//  Brief    : MSB-first frame shift register with a down-counting bit index.
//  Revision : 1.0  initial release
// ============================================================================
module seq_frame_shifter
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic             shift,
  input  wire logic [PAT_W-1:0] frame_in,
  output logic                  bit_out,
  output logic                  last_bit
);

  localparam int                 c_IDX_W = idx_w(PAT_W);
  localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(PAT_W - 1);

  logic [PAT_W-1:0]   r_sr;
  logic [c_IDX_W-1:0] r_idx;

  // load takes priority so a frame reload can coincide with the last shift slot
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr  <= '0;
      r_idx <= '0;
    end else if (load) begin
      r_sr  <= frame_in;
      r_idx <= c_IDX_TOP;
    end else if (shift) begin
      r_sr  <= {r_sr[PAT_W-2:0], 1'b0};
      r_idx <= r_idx - 1'b1;
    end
  end

  assign bit_out  = r_sr[PAT_W-1];
  assign last_bit = (r_idx == '0);

endmodule
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_gen
//  Brief    : Serial test-pattern transmitter; shifts a frame out MSB-first
//             rpt+1 times. Macro SEQ_GEN_PARITY_EN appends an even-parity bit.
//  Revision : 1.0  initial release
// ============================================================================
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int               PAT_W       = DEF_PAT_W,
  parameter int               CNT_W       = DEF_CNT_W,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(DEF_PAT_DEFAULT)
) (
  input wire logic         clk,
  input wire logic         reset,
  seq_pattern_gen_if.slave bus
);

  logic [1:0]       r_state;
  logic [PAT_W-1:0] r_frame;
  logic [CNT_W-1:0] r_rpt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic             w_bit;
  logic             w_last;
  logic             w_active;
  logic             w_more;
  logic             w_frame_end;
  logic             w_load;
  logic             w_shift;
  logic             w_out;
  logic [PAT_W-1:0] w_new_frame;
  logic [PAT_W-1:0] w_frame_in;

  assign w_new_frame = bus.use_default ? PAT_DEFAULT : bus.pattern;
  assign w_active    = (r_state != c_IDLE) && !bus.hold;
  assign w_more      = (r_cnt < r_rpt);

`ifdef SEQ_GEN_PARITY_EN
  logic r_par;
  logic w_to_parity;
  assign w_to_parity = w_active && (r_state == c_SHIFT) && w_last;
  assign w_frame_end = w_active && (r_state == c_PARITY);
`else
  assign w_frame_end = w_active && (r_state == c_SHIFT) && w_last;
`endif

  assign w_load     = ((r_state == c_IDLE) && bus.start) || (w_frame_end && w_more);
  assign w_shift    = w_active && (r_state == c_SHIFT) && !w_last;
  assign w_frame_in = (r_state == c_IDLE) ? w_new_frame : r_frame;

  seq_frame_shifter #(
    .PAT_W (PAT_W)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .shift    (w_shift),
    .frame_in (w_frame_in),
    .bit_out  (w_bit),
    .last_bit (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_frame <= '0;
      r_rpt   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_state <= c_SHIFT;
            r_frame <= w_new_frame;
            r_rpt   <= bus.rpt;
            r_cnt   <= '0;
`ifdef SEQ_GEN_PARITY_EN
            r_par   <= ^w_new_frame;
`endif
          end
        end
        c_SHIFT: begin
`ifdef SEQ_GEN_PARITY_EN
          if (w_to_parity) begin
            r_state <= c_PARITY;
          end
`else
          if (w_frame_end) begin
            if (w_more) begin
              r_cnt <= r_cnt + 1'b1;
            end else begin
              r_state <= c_IDLE;
              r_done  <= 1'b1;
            end
          end
`endif
        end
`ifdef SEQ_GEN_PARITY_EN
        c_PARITY: begin
          if (w_frame_end) begin
            if (w_more) begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= c_SHIFT;
            end else begin
              r_state <= c_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_comb begin
    w_out = 1'b0;
    case (r_state)
      c_SHIFT:  w_out = w_bit;
`ifdef SEQ_GEN_PARITY_EN
      c_PARITY: w_out = r_par;
`endif
      default:  w_out = 1'b0;
    endcase
  end

  assign bus.out       = w_out;
  assign bus.out_valid = (r_state != c_IDLE);
  assign bus.busy      = (r_state != c_IDLE);
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_pattern_gen
//  Brief    : Self-checking bench for seq_pattern_gen against a stream model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_pattern_gen;

  localparam int         PAT_W = 4;
  localparam int         CNT_W = 4;
  localparam logic [3:0] PDEF  = 4'b1010;
`ifdef SEQ_GEN_PARITY_EN
  localparam int FRAME_LEN = PAT_W + 1;
`else
  localparam int FRAME_LEN = PAT_W;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   exp_q[$];

  seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_gen #(
    .PAT_W       (PAT_W),
    .CNT_W       (CNT_W),
    .PAT_DEFAULT (PDEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected serial stream: nfr copies of the frame, MSB first, optional parity.
  function automatic void build_stream(input logic [3:0] f, input int nfr);
    exp_q.delete();
    for (int fr = 0; fr < nfr; fr++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back(f[b]);
`ifdef SEQ_GEN_PARITY_EN
      exp_q.push_back(^f);
`endif
    end
  endfunction

  // Starts a burst from idle (at a negedge) and checks every cycle to idle.
  task automatic run_burst(input logic [3:0] pat, input bit use_def, input logic [3:0] r,
                           input int hold_pct, input int hold_at, input int hold_len,
                           input bit noise, input string tag);
    logic [3:0] got;
    logic [3:0] exp;
    int         p;
    int         hleft;
    int         guard;
    bit         h;
    build_stream(use_def ? PDEF : pat, int'(r) + 1);
    bus.start = 1'b1; bus.use_default = use_def; bus.pattern = pat; bus.rpt = r; bus.hold = 1'b0;
    @(negedge clk);
    p = 0; hleft = hold_len; guard = 0;
    while (p < exp_q.size()) begin
      got = {bus.busy, bus.out_valid, bus.out, bus.done};
      exp = {1'b1, 1'b1, exp_q[p], 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s bit %0d: busy/valid/out/done=%b expected %b", tag, p, got, exp);
      end
      h = (p == hold_at && hleft > 0) || (hold_pct > 0 && int'($urandom_range(99)) < hold_pct);
      if (p == hold_at && hleft > 0) hleft--;
      bus.hold = h;
      if (noise) begin
        bus.start       = 1'($urandom_range(1));
        bus.use_default = 1'($urandom_range(1));
        bus.pattern     = 4'($urandom);
        bus.rpt         = 4'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (!h) p++;
      guard++;
      if (guard > 4000) begin
        checks++; errors++;
        $display("FAIL %s timeout: stream stuck at bit %0d expected end %0d", tag, p, exp_q.size());
        break;
      end
      @(negedge clk);
    end
    got = {bus.busy, bus.out_valid, bus.out, bus.done};
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL %s done cycle: busy/valid/out/done=%b expected 0001", tag, got);
    end
    bus.start = 1'b0;
    bus.hold  = noise ? 1'($urandom_range(1)) : 1'b0;
    @(negedge clk);
    got = {bus.busy, bus.out_valid, bus.out, bus.done};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL %s idle after done: busy/valid/out/done=%b expected 0000", tag, got);
    end
    bus.hold = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    reset = 1'b1; bus.start = 1'b1; bus.hold = 1'b0;
    bus.use_default = 1'b1; bus.pattern = 4'hF; bus.rpt = 4'd3;
    repeat (3) @(negedge clk);
    got = {bus.busy, bus.out_valid, bus.out, bus.done};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset held: busy/valid/out/done=%b expected 0000", got);
    end
    reset = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    got = {bus.busy, bus.out_valid, bus.out, bus.done};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset release: busy/valid/out/done=%b expected 0000", got);
    end
  endtask

  task automatic test_default();
    run_burst(4'b0000, 1'b1, 4'd0, 0, -1, 0, 1'b0, "default_pattern");
  endtask

  task automatic test_repeat();
    run_burst(4'b1100, 1'b0, 4'd2, 0, -1, 0, 1'b0, "repeat_1100");
  endtask

  task automatic test_hold();
    run_burst(4'b1010, 1'b0, 4'd0, 0, 1, 3, 1'b0, "hold_second_bit");
  endtask

  task automatic test_parity_frame();
    run_burst(4'b1011, 1'b0, 4'd1, 0, -1, 0, 1'b0, "frame_1011_x2");
  endtask

  task automatic test_max_rpt();
    run_burst(4'b0110, 1'b0, 4'd15, 0, -1, 0, 1'b0, "max_rpt");
  endtask

  task automatic test_reset_midburst();
    logic [3:0] got;
    logic [3:0] pat;
    pat = 4'($urandom);
    bus.start = 1'b1; bus.use_default = 1'b0; bus.pattern = pat; bus.rpt = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = {bus.busy, bus.out_valid, bus.out, bus.done};
      checks++;
      if (got !== {1'b1, 1'b1, pat[PAT_W-1-i], 1'b0}) begin
        errors++;
        $display("FAIL midreset bit %0d: busy/valid/out/done=%b expected %b", i, got,
                 {1'b1, 1'b1, pat[PAT_W-1-i], 1'b0});
      end
      if (i == 2) reset = 1'b1;
      @(negedge clk);
    end
    got = {bus.busy, bus.out_valid, bus.out, bus.done};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL midreset abort: busy/valid/out/done=%b expected 0000", got);
    end
    reset = 1'b0;
    @(negedge clk);
    got = {bus.busy, bus.out_valid, bus.out, bus.done};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL midreset no done: busy/valid/out/done=%b expected 0000", got);
    end
    run_burst(4'($urandom), 1'b0, 4'd3, 0, -1, 0, 1'b0, "after_midreset");
  endtask

  task automatic test_back_to_back();
    logic [3:0] got;
    logic [3:0] exp;
    build_stream(4'b1010, 1);
    bus.start = 1'b1; bus.use_default = 1'b0; bus.pattern = 4'b1010; bus.rpt = 4'd0; bus.hold = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        got = {bus.busy, bus.out_valid, bus.out, bus.done};
        exp = {1'b1, 1'b1, exp_q[i], 1'b0};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL b2b burst %0d bit %0d: busy/valid/out/done=%b expected %b", k, i, got, exp);
        end
        @(negedge clk);
      end
      got = {bus.busy, bus.out_valid, bus.out, bus.done};
      checks++;
      if (got !== 4'b0001) begin
        errors++;
        $display("FAIL b2b done %0d: busy/valid/out/done=%b expected 0001", k, got);
      end
      if (k == 2) bus.start = 1'b0;
      @(negedge clk);
    end
    got = {bus.busy, bus.out_valid, bus.out, bus.done};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL b2b final idle: busy/valid/out/done=%b expected 0000", got);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      run_burst(4'($urandom), 1'($urandom_range(1)), 4'($urandom_range(15)),
                20, -1, 0, 1'b1, $sformatf("random_%0d", n));
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.use_default = 1'b0; bus.pattern = '0; bus.rpt = '0; bus.hold = 1'b0;
    @(negedge clk);
    test_reset();
    test_default();
    test_repeat();
    test_hold();
    test_parity_frame();
    test_max_rpt();
    test_reset_midburst();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial test-pattern transmitter for the sequence-detector family. It loads a PAT_W-bit pattern on a start request and shifts it out MSB-first, one bit per clock, repeating the frame a programmable number of times. It sits ahead of any serial detector under test, or acts as a stimulus source inside self-checking top levels. It reports busy and a one-cycle done pulse.

Parameters:
- PAT_W, 4, pattern/frame width in bits (>=2).
- CNT_W, 4, width of the repeat-count input.
- PAT_DEFAULT, 4'b1010, pattern used when use_default=1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin a burst; honoured only in IDLE.
- use_default  input  1  1 = transmit PAT_DEFAULT and ignore pattern.
- pattern  input  PAT_W  frame to transmit, sampled on the accepting edge.
- rpt  input  CNT_W  number of extra frames; burst length = rpt+1 frames.
- hold  input  1  stall; freezes all internal state while high.
- out  output  1  serial data bit.
- out_valid  output  1  high while out carries a pattern bit.
- busy  output  1  high from the accepting edge until the last bit leaves.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset).
- Reset, sampled at a rising edge, forces: state=IDLE, out=0, out_valid=0, busy=0, done=0, and clears the shift register and counters. Reset wins over every other input, including in mid-burst; any partial frame is abandoned and done is not pulsed.
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the optional feature).
- IDLE:
  - done is cleared on the edge after its pulse.
  - An edge with start=1 latches the frame (PAT_DEFAULT if use_default=1, else pattern) and latches rpt.
  - On that same edge: state becomes SHIFT, out=frame[PAT_W-1], out_valid=1, busy=1.
  - Latency is therefore one cycle from start to the first bit.
- SHIFT, on each edge with hold=0, the next bit is presented (MSB to LSB).
  - After bit 0 of a frame, if the frame counter is less than the latched rpt: reload the same frame, present its MSB on the very next edge (no gap between frames), and increment the frame counter.
  - After bit 0 of the last frame: state becomes IDLE, out=0, out_valid=0, busy=0, done=1 for exactly one cycle.
- hold=1 at an edge in SHIFT or PARITY: nothing changes, so the current bit is stretched and out_valid stays 1. hold is ignored in IDLE.
- start while busy=1 is ignored and not queued.
- start=1 in the done cycle is accepted, because state is already IDLE. The new burst begins on that edge and done still deasserts on that edge.
- Changes to pattern, use_default or rpt during a burst have no effect.
- rpt=0 gives one frame. rpt=2^CNT_W-1 gives 2^CNT_W frames; the frame counter is CNT_W wide and does not wrap early.
- Burst length without parity: (rpt+1)*PAT_W valid cycles, plus any hold cycles.

Optional Feature:
- Macro: SEQ_GEN_PARITY_EN.
- Defined: after bit 0 of each frame, the block enters PARITY for one valid cycle. In that cycle out = XOR of all frame bits (even parity) and out_valid=1. The frame-repeat and done decisions move to the PARITY exit. Frame length becomes PAT_W+1.
- Not defined: the PARITY state and its logic are absent, and the frame is exactly PAT_W bits.

Decomposition:
- Package seq_gen_pkg holds:
  - the state encoding constants (IDLE, SHIFT, PARITY);
  - default PAT_W, CNT_W and PAT_DEFAULT;
  - a function computing the bit-index width from PAT_W.
- One sub-module, seq_frame_shifter: load/shift register plus bit-index counter, with ports load, shift, frame_in, bit_out, last_bit. The top level owns the FSM, the frame counter, hold gating and the parity bit.

Test Plan:
- Reset release, then start=1 with use_default=1 and rpt=0 -> out = 1,0,1,0 on the 4 cycles after the start edge, out_valid high for exactly 4 cycles, then done=1 for one cycle and busy=0.
- pattern=4'b1100, rpt=2 -> 12 consecutive valid bits 110011001100 with no gaps, a single done pulse, and busy high for 12 cycles.
- Burst 1010, hold=1 for 3 cycles during the second bit -> stream 1,0,0,0,0,1,0; done is delayed by 3 cycles.
- reset=1 during the third bit of a rpt=3 burst -> the next edge gives out=0, out_valid=0, busy=0, with no done pulse; a following start runs a clean full burst.
- start held high continuously with rpt=0, pattern 1010 -> back-to-back bursts, each preceded by one idle cycle carrying done=1; start pulses arriving mid-burst are ignored.
- With SEQ_GEN_PARITY_EN, pattern 4'b1011, rpt=1 -> 1011 1 1011 1 (10 valid cycles), then done.
